// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, flit field layout and XY route function
package router_pkg;

    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_N     = 1;
    localparam int unsigned PORT_E     = 2;
    localparam int unsigned PORT_S     = 3;
    localparam int unsigned PORT_W     = 4;
    localparam int unsigned MAX_PORTS  = 5;

    // Flag bits sit at PORT_WIDTH - offset so the layout holds for any flit width.
    localparam int unsigned HEAD_OFS   = 1;
    localparam int unsigned TAIL_OFS   = 2;

    localparam int unsigned DST_X_LSB  = 0;
    localparam int unsigned MAX_COORD_W = 16;

    typedef logic [MAX_PORTS-1:0]   route_vec_t;
    typedef logic [MAX_COORD_W-1:0] coord_t;

    function automatic route_vec_t xy_route(input coord_t cur_x, input coord_t cur_y,
                                            input coord_t dst_x, input coord_t dst_y);
        route_vec_t r;
        r = '0;
        if (dst_x > cur_x)      r[PORT_E] = 1'b1;
        else if (dst_x < cur_x) r[PORT_W] = 1'b1;
        else if (dst_y > cur_y) r[PORT_N] = 1'b1;
        else if (dst_y < cur_y) r[PORT_S] = 1'b1;
        else                    r[PORT_LOCAL] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/router_ingress_buffer_if.sv
// rtl/router_ingress_buffer_if.sv - upstream flit link plus switch-side request link
interface router_ingress_buffer_if #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 128
);
    logic                  in_val;
    logic [PORT_WIDTH-1:0] in_dat;
    logic                  in_rdy;
    logic                  out_val;
    logic [PORT_WIDTH-1:0] out_dat;
    logic [NUM_PORTS:0]    out_req;
    logic                  out_rdy;

    modport master (
        output in_val, in_dat, out_rdy,
        input  in_rdy, out_val, out_dat, out_req
    );

    modport slave (
        input  in_val, in_dat, out_rdy,
        output in_rdy, out_val, out_dat, out_req
    );
endinterface

// File: rtl/router_sync_fifo.sv
// rtl/router_sync_fifo.sv - registered-storage synchronous FIFO, no write-to-read bypass
module router_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             do_push, do_pop;

    assign full    = (fill_q == (AW+1)'(DEPTH));
    assign empty   = (fill_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign fill    = fill_q;

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/router_ingress_buffer.sv
// rtl/router_ingress_buffer.sv - ingress FIFO with XY route request held for the whole packet
module router_ingress_buffer
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 128,
    parameter int DEPTH      = 4,
    parameter int COORD_W    = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [COORD_W-1:0]     cur_x,
    input  logic [COORD_W-1:0]     cur_y,
    router_ingress_buffer_if.slave link,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   err_drop
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NUM_PORTS:0]    route_q, route_d;
    logic [PORT_WIDTH-1:0] front;
    logic                  full, empty, push, pop, drop;
    logic                  front_head, front_tail;
    route_vec_t            route_full;
    logic [NUM_PORTS:0]    route_now;

    assign front_head = front[PORT_WIDTH-HEAD_OFS];
    assign front_tail = front[PORT_WIDTH-TAIL_OFS];

    assign route_full = xy_route(coord_t'(cur_x), coord_t'(cur_y),
                                 coord_t'(front[DST_X_LSB +: COORD_W]),
                                 coord_t'(front[DST_X_LSB+COORD_W +: COORD_W]));
    assign route_now  = route_full[NUM_PORTS:0];

    assign link.in_rdy  = !full;
    assign link.out_dat = front;
    assign push         = link.in_val && !full;
    assign pop          = (link.out_val && link.out_rdy) || drop;
    assign err_drop     = drop;

    router_sync_fifo #(
        .WIDTH (PORT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (push),
        .pop   (pop),
        .wdata (link.in_dat),
        .rdata (front),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    // A headless flit at the front in IDLE is never presented; it is discarded in place.
    always_comb begin
        link.out_val = 1'b0;
        link.out_req = '0;
        drop         = 1'b0;
        state_d      = state_q;
        route_d      = route_q;
        if (state_q == ST_IDLE) begin
            if (!empty) begin
                if (front_head) begin
                    link.out_val = 1'b1;
                    link.out_req = route_now;
                    if (link.out_rdy && !front_tail) begin
                        state_d = ST_BODY;
                        route_d = route_now;
                    end
                end else begin
                    drop = 1'b1;
                end
            end
        end else begin
            link.out_val = !empty;
            link.out_req = empty ? '0 : route_q;
            if (!empty && link.out_rdy && front_tail) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

endmodule

// File: tb/tb_router_ingress_buffer.sv
// tb/tb_router_ingress_buffer.sv - directed and randomized checks against a queue-based flit model
module tb_router_ingress_buffer;
    localparam int NP = 4;
    localparam int PW = 128;
    localparam int DEPTH = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic [CW-1:0] cur_x, cur_y;
    logic [$clog2(DEPTH):0] fill;
    logic          err_drop;

    router_ingress_buffer_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW)) link();

    router_ingress_buffer #(
        .NUM_PORTS (NP),
        .PORT_WIDTH(PW),
        .DEPTH     (DEPTH),
        .COORD_W   (CW)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .link     (link),
        .fill     (fill),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [PW-1:0] model_q[$];
    bit            in_pkt;
    logic [NP:0]   route_m;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP:0] ref_route(input int cx, input int cy, input int dx, input int dy);
        int p;
        if (dx > cx)      p = 2;
        else if (dx < cx) p = 4;
        else if (dy > cy) p = 1;
        else if (dy < cy) p = 3;
        else              p = 0;
        return (NP+1)'(1 << p);
    endfunction

    function automatic logic [PW-1:0] mk_flit(input bit h, input bit t, input int dx, input int dy);
        logic [PW-1:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        f[PW-1] = h;
        f[PW-2] = t;
        f[3:0]  = CW'(dx);
        f[7:4]  = CW'(dy);
        return f;
    endfunction

    // Drive one cycle from the negedge, check outputs against the model, then advance the model.
    task automatic cycle(input bit v, input logic [PW-1:0] d, input bit r);
        bit            exp_val, exp_drop, hd, tl, do_push, do_pop;
        logic [NP:0]   exp_req;
        logic [PW-1:0] fr;
        link.in_val  = v;
        link.in_dat  = d;
        link.out_rdy = r;
        #1;
        fr = '0;
        if (model_q.size() > 0) fr = model_q[0];
        hd = fr[PW-1];
        tl = fr[PW-2];
        exp_val  = (model_q.size() > 0) && (in_pkt || hd);
        exp_drop = (model_q.size() > 0) && !in_pkt && !hd;
        exp_req  = !exp_val ? '0 : in_pkt ? route_m : ref_route(cur_x, cur_y, fr[3:0], fr[7:4]);
        chk("out_val", link.out_val, exp_val);
        chk("out_req", link.out_req, exp_req);
        chk("fill", fill, model_q.size());
        chk("in_rdy", link.in_rdy, model_q.size() < DEPTH);
        chk("err_drop", err_drop, exp_drop);
        if (exp_val) chk("out_dat", link.out_dat, fr);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = exp_drop || (exp_val && r);
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
            if (!exp_drop) begin
                if (!in_pkt && !tl) begin
                    in_pkt  = 1'b1;
                    route_m = ref_route(cur_x, cur_y, fr[3:0], fr[7:4]);
                end else if (in_pkt && tl) begin
                    in_pkt = 1'b0;
                end
            end
        end
        if (do_push) model_q.push_back(d);
        @(negedge clk);
    endtask

    initial begin
        logic [PW-1:0] f;
        arst = 1'b1;
        link.in_val = 1'b0;
        link.in_dat = '0;
        link.out_rdy = 1'b0;
        cur_x = 4'd1;
        cur_y = 4'd1;
        in_pkt = 1'b0;
        route_m = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_val", link.out_val, 1'b0);
        chk("rst_fill", fill, 0);
        chk("rst_in_rdy", link.in_rdy, 1'b1);
        arst = 1'b0;
        @(negedge clk);

        // Single-flit packet routed E
        cycle(1, mk_flit(1, 1, 3, 1), 1);
        chk("e_req", link.out_req, 5'b00100);
        chk("e_val", link.out_val, 1'b1);
        cycle(0, '0, 1);
        chk("e_gone", link.out_val, 1'b0);

        // Three-flit packet routed S with a stall on flit 2
        cycle(1, mk_flit(1, 0, 1, 0), 0);
        cycle(1, mk_flit(0, 0, 9, 9), 1);
        cycle(1, mk_flit(1, 1, 3, 3), 0);
        chk("s_stall_req", link.out_req, 5'b01000);
        cycle(0, '0, 0);
        chk("s_stall_req2", link.out_req, 5'b01000);
        cycle(0, '0, 1);
        cycle(0, '0, 1);
        cycle(1, mk_flit(1, 1, 1, 1), 0);
        chk("local_req", link.out_req, 5'b00001);
        cycle(0, '0, 1);

        // Full FIFO: 5 offered, 4 taken
        for (int i = 0; i < 4; i++) cycle(1, mk_flit(i == 0, 0, 0, 1), 0);
        chk("full_fill", fill, 4);
        chk("full_rdy", link.in_rdy, 1'b0);
        f = mk_flit(0, 1, 0, 1);
        cycle(1, f, 0);
        chk("full_held", fill, 4);
        cycle(1, f, 1);
        chk("pop_fill", fill, 3);
        chk("pop_rdy", link.in_rdy, 1'b1);
        cycle(1, f, 0);
        chk("fifth_in", fill, 4);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1);
        chk("drained", fill, 0);

        // Malformed flit followed by a valid head
        cycle(1, mk_flit(0, 1, 2, 2), 0);
        chk("drop_pulse", err_drop, 1'b1);
        chk("drop_noval", link.out_val, 1'b0);
        cycle(1, mk_flit(1, 1, 2, 1), 0);
        chk("drop_end", err_drop, 1'b0);
        chk("drop_fill", fill, 1);
        chk("after_drop_req", link.out_req, 5'b00100);
        cycle(0, '0, 1);

        // Asynchronous reset with two flits stored
        cycle(1, mk_flit(1, 0, 3, 3), 0);
        cycle(1, mk_flit(0, 0, 3, 3), 0);
        #2 arst = 1'b1;
        #1;
        chk("arst_val", link.out_val, 1'b0);
        chk("arst_req", link.out_req, 5'b00000);
        chk("arst_fill", fill, 0);
        chk("arst_rdy", link.in_rdy, 1'b1);
        model_q.delete();
        in_pkt = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        cycle(1, mk_flit(1, 1, 1, 2), 0);
        chk("post_rst_req", link.out_req, 5'b00010);
        cycle(0, '0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 0) begin
                cur_x = CW'($urandom_range(0, 3));
                cur_y = CW'($urandom_range(0, 3));
            end
            cycle(($urandom % 3) != 0,
                  mk_flit(($urandom % 4) != 0, ($urandom % 2) != 0,
                          $urandom_range(0, 3), $urandom_range(0, 3)),
                  ($urandom % 4) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
